// File: rtl/target_spawner_pkg.sv
// Shared types and constants for the target spawner: FSM states, widths and LFSR defaults.
package target_spawner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SPAWN    = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_GAMEOVER = 2'd3
    } state_t;

    localparam int COORD_W = 11;
    localparam int SCORE_W = 8;

    // Fibonacci taps 16,14,13,11 as a mask over q[15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/target_spawner_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; returns to SEED while reset is low.
module lfsr16
    import target_spawner_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    // State register, advances every cycle out of reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= SEED;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/target_spawner.sv
// Target spawner: places a square at pseudo-random positions, scores hits, counts timeouts.
// Optional run-time speed-up of the timeout is enabled by defining TARGET_SPAWNER_SPEEDUP_EN.
module target_spawner
    import target_spawner_pkg::*;
#(
    parameter int          SIZE       = 10,
    parameter int          SCREEN_W   = 640,
    parameter int          SCREEN_H   = 480,
    parameter int          TIMEOUT    = 50_000_000,
    parameter int          MAX_MISSES = 5,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               hit,
    output logic [COORD_W-1:0] square_x0,
    output logic [COORD_W-1:0] square_y0,
    output logic               square_valid,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] misses,
    output logic               game_over
);

    localparam int                 CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [COORD_W-1:0] X_MAX     = COORD_W'(SCREEN_W - SIZE - 1);
    localparam logic [COORD_W-1:0] Y_MAX     = COORD_W'(SCREEN_H - SIZE - 1);
    localparam logic [SCORE_W-1:0] MISS_LAST = SCORE_W'(MAX_MISSES - 1);

    logic [15:0]        lfsr_q;
    logic [COORD_W-1:0] cand_x_s, cand_y_s;
    logic [CNT_W-1:0]   load_s;

    state_t             state_r, state_s;
    logic [COORD_W-1:0] x0_r, x0_s, y0_r, y0_s;
    logic               x_done_r, x_done_s, y_done_r, y_done_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               first_r, first_s;
    logic [SCORE_W-1:0] score_r, score_s, misses_r, misses_s;
    logic               valid_r, valid_s, over_r, over_s;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    assign cand_x_s = {1'b0, lfsr_q[9:0]};
    assign cand_y_s = {2'b00, lfsr_q[15:7]};

`ifdef TARGET_SPAWNER_SPEEDUP_EN
    localparam logic [CNT_W-1:0] TMO_STEP  = CNT_W'(TIMEOUT >> 4);
    localparam logic [CNT_W-1:0] TMO_FLOOR = CNT_W'(TIMEOUT >> 2);
    logic [CNT_W-1:0] tmo_r, tmo_s;
    assign load_s = tmo_r - {{(CNT_W-1){1'b0}}, 1'b1};
`else
    assign load_s = CNT_W'(TIMEOUT - 1);
`endif

    // Next-state and next-output logic for the game FSM
    always_comb begin
        state_s  = state_r;
        x0_s     = x0_r;
        y0_s     = y0_r;
        x_done_s = x_done_r;
        y_done_s = y_done_r;
        cnt_s    = cnt_r;
        first_s  = first_r;
        score_s  = score_r;
        misses_s = misses_r;
`ifdef TARGET_SPAWNER_SPEEDUP_EN
        tmo_s    = tmo_r;
`endif
        case (state_r)
            ST_IDLE, ST_GAMEOVER: begin
                if (start) begin
                    score_s  = {SCORE_W{1'b0}};
                    misses_s = {SCORE_W{1'b0}};
                    x_done_s = 1'b0;
                    y_done_s = 1'b0;
`ifdef TARGET_SPAWNER_SPEEDUP_EN
                    tmo_s    = CNT_W'(TIMEOUT);
`endif
                    state_s  = ST_SPAWN;
                end else begin
                    state_s  = state_r;
                end
            end
            ST_SPAWN: begin
                // Rejection sampling: each axis keeps the first in-range candidate it sees
                if (!x_done_r && (cand_x_s <= X_MAX)) begin
                    x0_s     = cand_x_s;
                    x_done_s = 1'b1;
                end else begin
                    x0_s     = x0_r;
                end
                if (!y_done_r && (cand_y_s <= Y_MAX)) begin
                    y0_s     = cand_y_s;
                    y_done_s = 1'b1;
                end else begin
                    y0_s     = y0_r;
                end
                if (x_done_s && y_done_s) begin
                    cnt_s    = load_s;
                    first_s  = 1'b1;
                    x_done_s = 1'b0;
                    y_done_s = 1'b0;
                    state_s  = ST_ACTIVE;
                end else begin
                    state_s  = ST_SPAWN;
                end
            end
            ST_ACTIVE: begin
                first_s = 1'b0;
                // A hit wins over a coincident timeout; the first cycle ignores stale hits
                if (hit && !first_r) begin
                    if (score_r != {SCORE_W{1'b1}}) begin
                        score_s = score_r + {{(SCORE_W-1){1'b0}}, 1'b1};
                    end else begin
                        score_s = score_r;
                    end
`ifdef TARGET_SPAWNER_SPEEDUP_EN
                    if (tmo_r >= (TMO_FLOOR + TMO_STEP)) begin
                        tmo_s = tmo_r - TMO_STEP;
                    end else begin
                        tmo_s = TMO_FLOOR;
                    end
`endif
                    state_s = ST_SPAWN;
                end else if (cnt_r == {CNT_W{1'b0}}) begin
                    misses_s = misses_r + {{(SCORE_W-1){1'b0}}, 1'b1};
                    if (misses_r == MISS_LAST) begin
                        state_s = ST_GAMEOVER;
                    end else begin
                        state_s = ST_SPAWN;
                    end
                end else begin
                    cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        valid_s = (state_s == ST_ACTIVE);
        over_s  = (state_s == ST_GAMEOVER);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            x0_r     <= {COORD_W{1'b0}};
            y0_r     <= {COORD_W{1'b0}};
            x_done_r <= 1'b0;
            y_done_r <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            first_r  <= 1'b0;
            score_r  <= {SCORE_W{1'b0}};
            misses_r <= {SCORE_W{1'b0}};
            valid_r  <= 1'b0;
            over_r   <= 1'b0;
`ifdef TARGET_SPAWNER_SPEEDUP_EN
            tmo_r    <= CNT_W'(TIMEOUT);
`endif
        end else begin
            state_r  <= state_s;
            x0_r     <= x0_s;
            y0_r     <= y0_s;
            x_done_r <= x_done_s;
            y_done_r <= y_done_s;
            cnt_r    <= cnt_s;
            first_r  <= first_s;
            score_r  <= score_s;
            misses_r <= misses_s;
            valid_r  <= valid_s;
            over_r   <= over_s;
`ifdef TARGET_SPAWNER_SPEEDUP_EN
            tmo_r    <= tmo_s;
`endif
        end
    end

    assign square_x0    = x0_r;
    assign square_y0    = y0_r;
    assign square_valid = valid_r;
    assign score        = score_r;
    assign misses       = misses_r;
    assign game_over    = over_r;

endmodule

// File: tb/tb_target_spawner.sv
// Directed self-checking bench for target_spawner with TIMEOUT=20 and MAX_MISSES=3.
module tb_target_spawner;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        hit;
    logic [10:0] square_x0;
    logic [10:0] square_y0;
    logic        square_valid;
    logic [7:0]  score;
    logic [7:0]  misses;
    logic        game_over;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    target_spawner #(
        .TIMEOUT    (20),
        .MAX_MISSES (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .hit          (hit),
        .square_x0    (square_x0),
        .square_y0    (square_y0),
        .square_valid (square_valid),
        .score        (score),
        .misses       (misses),
        .game_over    (game_over)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, output int lat);
        lat = 0;
        while (square_valid !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        checks++;
        if (square_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s: square_valid=%b after %0d cycles, required 1", name, square_valid, lat);
        end
    endtask

    // Counts the cycles a target stays up with no hit; checks position stability while up.
    task automatic measure_up(input string name, output int n);
        int lat;
        logic [10:0] px, py;
        bit stable;
        wait_valid(name, lat);
        px = square_x0;
        py = square_y0;
        stable = 1'b1;
        n = 1;
        while (n < 100) begin
            tick();
            if (square_valid !== 1'b1) break;
            n++;
            if (square_x0 !== px || square_y0 !== py) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            failures++;
            $display("FAIL %s_stable: position moved while valid, got 0 required 1", name);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        start = 1'b0;
        hit   = 1'b0;
        repeat (2) tick();
        checks += 6;
        if (square_x0 !== 11'd0) begin failures++; $display("FAIL rst_x0: got %0d required 0", square_x0); end
        if (square_y0 !== 11'd0) begin failures++; $display("FAIL rst_y0: got %0d required 0", square_y0); end
        if (square_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b required 0", square_valid); end
        if (score !== 8'd0) begin failures++; $display("FAIL rst_score: got %0d required 0", score); end
        if (misses !== 8'd0) begin failures++; $display("FAIL rst_misses: got %0d required 0", misses); end
        if (game_over !== 1'b0) begin failures++; $display("FAIL rst_game_over: got %b required 0", game_over); end
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (square_valid !== 1'b0 || game_over !== 1'b0) begin
                failures++;
                $display("FAIL idle_hold: cycle %0d valid=%b game_over=%b required 0/0", i, square_valid, game_over);
            end
        end
    endtask

    task automatic test_start_spawn;
        int lat;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (square_valid !== 1'b0) begin failures++; $display("FAIL spawn_not_instant: valid got %b required 0", square_valid); end
        wait_valid("first_spawn", lat);
        checks += 4;
        if (lat < 1) begin failures++; $display("FAIL spawn_latency: got %0d required >=1", lat); end
        if (square_x0 > 11'd629) begin failures++; $display("FAIL spawn_x_range: got %0d required <=629", square_x0); end
        if (square_y0 > 11'd469) begin failures++; $display("FAIL spawn_y_range: got %0d required <=469", square_y0); end
        if (score !== 8'd0 || misses !== 8'd0) begin
            failures++;
            $display("FAIL start_clear: score=%0d misses=%0d required 0/0", score, misses);
        end
    endtask

    // Target is up (first ACTIVE cycle) on entry.
    task automatic test_holdoff_hit;
        int lat;
        logic [10:0] px, py;
        px = square_x0;
        py = square_y0;
        hit = 1'b1;
        tick();
        hit = 1'b0;
        checks++;
        if (square_valid !== 1'b1 || score !== 8'd0) begin
            failures++;
            $display("FAIL holdoff: valid=%b score=%0d required 1/0", square_valid, score);
        end
        repeat (3) tick();
        hit = 1'b1;
        tick();
        hit = 1'b0;
        checks += 3;
        if (score !== 8'd1) begin failures++; $display("FAIL hit_score: got %0d required 1", score); end
        if (square_valid !== 1'b0) begin failures++; $display("FAIL hit_valid_drop: got %b required 0", square_valid); end
        if (square_x0 !== px || square_y0 !== py) begin
            failures++;
            $display("FAIL hit_pos_hold: got %0d,%0d required %0d,%0d", square_x0, square_y0, px, py);
        end
        wait_valid("respawn_after_hit", lat);
    endtask

    task automatic test_timeout;
        int n;
        for (int k = 1; k <= 3; k++) begin
            measure_up("timeout", n);
            checks += 3;
            if (n !== 20) begin failures++; $display("FAIL timeout_len: miss %0d got %0d cycles required 20", k, n); end
            if (misses !== 8'(k)) begin failures++; $display("FAIL timeout_misses: got %0d required %0d", misses, k); end
            if (score !== 8'd1) begin failures++; $display("FAIL timeout_score_hold: got %0d required 1", score); end
        end
        checks++;
        if (game_over !== 1'b1) begin failures++; $display("FAIL game_over_set: got %b required 1", game_over); end
        hit = 1'b1;
        repeat (4) tick();
        hit = 1'b0;
        checks++;
        if (game_over !== 1'b1 || square_valid !== 1'b0 || score !== 8'd1 || misses !== 8'd3) begin
            failures++;
            $display("FAIL game_over_hold: go=%b valid=%b score=%0d misses=%0d required 1/0/1/3",
                     game_over, square_valid, score, misses);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (score !== 8'd0 || misses !== 8'd0 || game_over !== 1'b0) begin
            failures++;
            $display("FAIL restart_clear: score=%0d misses=%0d go=%b required 0/0/0", score, misses, game_over);
        end
    endtask

    task automatic test_coincident;
        int lat;
        wait_valid("coincident_wait", lat);
        repeat (19) tick();
        checks++;
        if (square_valid !== 1'b1) begin failures++; $display("FAIL last_cycle_valid: got %b required 1", square_valid); end
        hit = 1'b1;
        tick();
        checks++;
        if (score !== 8'd1 || misses !== 8'd0 || square_valid !== 1'b0) begin
            failures++;
            $display("FAIL coincident: score=%0d misses=%0d valid=%b required 1/0/0", score, misses, square_valid);
        end
        tick();
        hit = 1'b0;
        checks++;
        if (score !== 8'd1) begin failures++; $display("FAIL hit_in_spawn: score got %0d required 1", score); end
    endtask

    task automatic test_many_spawns;
        int lat;
        int exp_score;
        exp_score = 1;
        for (int i = 0; i < 260; i++) begin
            wait_valid("spawn_loop", lat);
            checks++;
            if (square_x0 > 11'd629 || square_y0 > 11'd469) begin
                failures++;
                $display("FAIL spawn_range: spawn %0d at %0d,%0d required <=629,<=469", i, square_x0, square_y0);
            end
            tick();
            hit = 1'b1;
            tick();
            hit = 1'b0;
            if (exp_score < 255) exp_score++;
            checks++;
            if (score !== 8'(exp_score) || square_valid !== 1'b0) begin
                failures++;
                $display("FAIL loop_hit: spawn %0d score=%0d valid=%b required %0d/0", i, score, square_valid, exp_score);
            end
        end
        checks++;
        if (score !== 8'd255 || misses !== 8'd0) begin
            failures++;
            $display("FAIL score_saturate: score=%0d misses=%0d required 255/0", score, misses);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        wait_valid("reset_mid_wait", lat);
        tick();
        #2;
        reset = 1'b0;
        #1;
        checks += 2;
        if (square_valid !== 1'b0 || score !== 8'd0 || misses !== 8'd0 || game_over !== 1'b0 ||
            square_x0 !== 11'd0 || square_y0 !== 11'd0) begin
            failures++;
            $display("FAIL async_reset: valid=%b score=%0d misses=%0d go=%b x=%0d y=%0d required all 0",
                     square_valid, score, misses, game_over, square_x0, square_y0);
        end
        if (dut.u_lfsr.q !== 16'hACE1) begin failures++; $display("FAIL lfsr_seed: got %h required ace1", dut.u_lfsr.q); end
        tick();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (square_valid !== 1'b0 || game_over !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle: valid=%b go=%b required 0/0", square_valid, game_over);
        end
    endtask

`ifdef TARGET_SPAWNER_SPEEDUP_EN
    task automatic hit_one;
        int lat;
        wait_valid("speedup_hit", lat);
        tick();
        hit = 1'b1;
        tick();
        hit = 1'b0;
    endtask

    task automatic test_speedup;
        int n;
        start = 1'b1;
        tick();
        start = 1'b0;
        measure_up("speedup_t0", n);
        checks++;
        if (n !== 20) begin failures++; $display("FAIL speedup_initial: got %0d required 20", n); end
        repeat (4) hit_one();
        measure_up("speedup_t4", n);
        checks++;
        if (n !== 16) begin failures++; $display("FAIL speedup_after4: got %0d required 16", n); end
        repeat (12) hit_one();
        measure_up("speedup_floor", n);
        checks++;
        if (n !== 5) begin failures++; $display("FAIL speedup_floor: got %0d required 5", n); end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got running required finished");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_start_spawn();
        test_holdoff_hit();
        test_timeout();
        test_coincident();
        test_many_spawns();
        test_reset_mid();
`ifdef TARGET_SPAWNER_SPEEDUP_EN
        test_speedup();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
